// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame parameters, system clock.
package uart_pkg;

   localparam int unsigned CLK_FREQ_HZ    = 100_000_000;
   localparam int unsigned DEF_DATA_BITS  = 8;
   localparam int unsigned DEF_OVERSAMPLE = 16;
   localparam int unsigned DEF_SB_TICK    = 16;
   localparam int unsigned STATE_W        = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser; both flops preset to 1 so an idle-high line sees no false edge out of reset.
module uart_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver driven by a 16x oversampling tick; one done strobe per frame.
// Optional parity stage and parity_err output enabled by defining UART_RX_PARITY_EN.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int unsigned SB_TICK    = DEF_SB_TICK
`ifdef UART_RX_PARITY_EN
   ,
   parameter int unsigned PARITY_ODD = 0
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 s_tick,
   output logic [DATA_BITS-1:0] dout,
   output logic                 rx_done_tick,
   output logic                 frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_err
`endif
);

   localparam int unsigned S_W = $clog2(max_u(OVERSAMPLE, SB_TICK));
   localparam int unsigned N_W = $clog2(DATA_BITS);

   localparam logic [STATE_W-1:0] S_IDLE   = IDLE;
   localparam logic [STATE_W-1:0] S_START  = START;
   localparam logic [STATE_W-1:0] S_DATA   = DATA;
   localparam logic [STATE_W-1:0] S_STOP   = STOP;
`ifdef UART_RX_PARITY_EN
   localparam logic [STATE_W-1:0] S_PARITY = PARITY;
   localparam logic [STATE_W-1:0] S_AFTER_DATA = S_PARITY;
`else
   localparam logic [STATE_W-1:0] S_AFTER_DATA = S_STOP;
`endif

   logic                 rx_s;
   logic [STATE_W-1:0]   state_q, state_d;
   logic [S_W-1:0]       s_q, s_d;
   logic [N_W-1:0]       n_q, n_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] dout_d;
   logic                 done_d;
   logic                 ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d;
   logic                 perr_d;
`endif

   uart_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         s_q          <= '0;
         n_q          <= '0;
         shift_q      <= '0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q        <= 1'b0;
         parity_err   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         n_q          <= n_d;
         shift_q      <= shift_d;
         dout         <= dout_d;
         rx_done_tick <= done_d;
         frame_err    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q        <= par_d;
         parity_err   <= perr_d;
`endif
      end
   end

   // Next-state and output logic; counters only move on s_tick
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shift_d = shift_q;
      dout_d  = dout;
      ferr_d  = frame_err;
      done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = parity_err;
`endif
      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               s_d     = '0;
            end
         end
         S_START: begin
            if (s_tick) begin
               if (s_q == S_W'(OVERSAMPLE/2 - 1)) begin
                  // Mid-bit confirm; a high line here was only a glitch
                  if (!rx_s) begin
                     state_d = S_DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         S_DATA: begin
            if (s_tick) begin
               if (s_q == S_W'(OVERSAMPLE - 1)) begin
                  s_d     = '0;
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (n_q == N_W'(DATA_BITS - 1)) begin
                     state_d = S_AFTER_DATA;
                  end else begin
                     n_d = n_q + N_W'(1);
                  end
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (s_tick) begin
               if (s_q == S_W'(OVERSAMPLE - 1)) begin
                  s_d     = '0;
                  par_d   = rx_s;
                  state_d = S_STOP;
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
`endif
         S_STOP: begin
            if (s_tick) begin
               if (s_q == S_W'(SB_TICK - 1)) begin
                  state_d = S_IDLE;
                  dout_d  = shift_q;
                  ferr_d  = ~rx_s;
                  done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                  perr_d  = (^shift_q) ^ par_q ^ 1'(PARITY_ODD);
`endif
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
